// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one memory read/write channel between icache (I) and dcache (D)
//
// Purpose:
//   Arbitrates the memory-side read channel between the instruction cache and
//   the data cache, and passes dcache writebacks through to the bridge. At most
//   one read and one write are outstanding at a time. Reads of a line whose
//   writeback has not completed are held off, so a refill never returns stale
//   data. All request/ready/return paths are combinational: zero added latency.
//
// Optional feature (macro RR_ARB_EN):
//   defined   - round-robin read arbitration using a 1-bit last_grant register
//   undefined - fixed priority, D over I
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   i_rd_req/type/addr, i_rd_rdy    icache read request channel
//   i_ret_valid/last/data           icache return beats
//   d_rd_req/type/addr, d_rd_rdy    dcache read request channel
//   d_ret_valid/last/data           dcache return beats
//   d_wr_req/type/addr/wstrb/data   dcache write request, d_wr_rdy accept
//   mem_rd_req/type/addr, rd_rdy    read request to bridge
//   mem_ret_valid/last/data         return beats from bridge
//   mem_wr_req/type/addr/wstrb/data write request to bridge, mem_wr_rdy accept
//   mem_wr_done                     one-cycle write response pulse

module cache_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int LINE_OFF_W = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_rd_req,
    input  logic [2:0]        i_rd_type,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              i_rd_rdy,
    output logic              i_ret_valid,
    output logic              i_ret_last,
    output logic [31:0]       i_ret_data,

    input  logic              d_rd_req,
    input  logic [2:0]        d_rd_type,
    input  logic [ADDR_W-1:0] d_rd_addr,
    output logic              d_rd_rdy,
    output logic              d_ret_valid,
    output logic              d_ret_last,
    output logic [31:0]       d_ret_data,

    input  logic              d_wr_req,
    input  logic [2:0]        d_wr_type,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [3:0]        d_wr_wstrb,
    input  logic [127:0]      d_wr_data,
    output logic              d_wr_rdy,

    output logic              mem_rd_req,
    output logic [2:0]        mem_rd_type,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_rdy,
    input  logic              mem_ret_valid,
    input  logic              mem_ret_last,
    input  logic [31:0]       mem_ret_data,

    output logic              mem_wr_req,
    output logic [2:0]        mem_wr_type,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [3:0]        mem_wr_wstrb,
    output logic [127:0]      mem_wr_data,
    input  logic              mem_wr_rdy,
    input  logic              mem_wr_done
);

    localparam int LINE_W = ADDR_W - LINE_OFF_W;

    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic {W_IDLE, W_BUSY} w_state_t;

    r_state_t            r_state;
    logic                owner_d;      // 1: D owns the in-flight read, 0: I
    w_state_t            w_state;
    logic [LINE_W-1:0]   pend_line;    // line of the writeback in flight

`ifdef RR_ARB_EN
    logic                last_grant_d; // 1: D won the last read grant
`endif

    logic [LINE_W-1:0]   i_line;
    logic [LINE_W-1:0]   d_line;
    logic [LINE_W-1:0]   w_line;

    logic                r_idle;
    logic                r_data;
    logic                w_idle;
    logic                w_busy;
    logic                wr_hs;
    logic                i_haz;
    logic                d_haz;
    logic                i_elig;
    logic                d_elig;
    logic                grant_d;
    logic                grant_i;
    logic                rd_hs;

    assign i_line = i_rd_addr[ADDR_W-1:LINE_OFF_W];
    assign d_line = d_rd_addr[ADDR_W-1:LINE_OFF_W];
    assign w_line = d_wr_addr[ADDR_W-1:LINE_OFF_W];

    // Qualifying the state decodes with reset forces every req/rdy/valid
    // output low while reset is held, regardless of the stored state.
    assign r_idle = (r_state == R_IDLE) & ~reset;
    assign r_data = (r_state == R_DATA) & ~reset;
    assign w_idle = (w_state == W_IDLE) & ~reset;
    assign w_busy = (w_state == W_BUSY) & ~reset;

    // ---------------------------------------------------------------
    // Write channel: pass-through while idle, blocked while in flight
    // ---------------------------------------------------------------
    assign mem_wr_req   = w_idle & d_wr_req;
    assign d_wr_rdy     = w_idle & mem_wr_rdy;
    assign mem_wr_type  = d_wr_type;
    assign mem_wr_addr  = d_wr_addr;
    assign mem_wr_wstrb = d_wr_wstrb;
    assign mem_wr_data  = d_wr_data;
    assign wr_hs        = mem_wr_req & mem_wr_rdy;

    // A line is hazarded while its writeback is outstanding, and also in the
    // very cycle the writeback is accepted (pend_line is not yet loaded).
    assign i_haz = (w_busy & (i_line == pend_line)) | (wr_hs & (i_line == w_line));
    assign d_haz = (w_busy & (d_line == pend_line)) | (wr_hs & (d_line == w_line));

    assign i_elig = r_idle & i_rd_req & ~i_haz;
    assign d_elig = r_idle & d_rd_req & ~d_haz;

    // ---------------------------------------------------------------
    // Read arbitration
    // ---------------------------------------------------------------
`ifdef RR_ARB_EN
    // On contention the port that did not win last time takes the grant.
    assign grant_d = d_elig & (~i_elig | ~last_grant_d);
`else
    assign grant_d = d_elig;
`endif
    assign grant_i = i_elig & ~grant_d;

    assign mem_rd_req  = grant_d | grant_i;
    assign mem_rd_addr = grant_d ? d_rd_addr : i_rd_addr;
    assign mem_rd_type = grant_d ? d_rd_type : i_rd_type;
    assign d_rd_rdy    = grant_d & mem_rd_rdy;
    assign i_rd_rdy    = grant_i & mem_rd_rdy;
    assign rd_hs       = mem_rd_req & mem_rd_rdy;

    // Return path: beats are steered to the owner only while a read is in
    // flight; beats arriving with no read outstanding are dropped.
    assign i_ret_valid = r_data & ~owner_d & mem_ret_valid;
    assign i_ret_last  = r_data & ~owner_d & mem_ret_last;
    assign d_ret_valid = r_data &  owner_d & mem_ret_valid;
    assign d_ret_last  = r_data &  owner_d & mem_ret_last;
    assign i_ret_data  = mem_ret_data;
    assign d_ret_data  = mem_ret_data;

    // ---------------------------------------------------------------
    // Read FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= R_IDLE;
            owner_d <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (rd_hs) begin
                        r_state <= R_DATA;
                        owner_d <= grant_d;
                    end
                end
                R_DATA: begin
                    if (mem_ret_valid & mem_ret_last) begin
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

`ifdef RR_ARB_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_d <= 1'b0;
        end else if (rd_hs) begin
            last_grant_d <= grant_d;
        end
    end
`endif

    // ---------------------------------------------------------------
    // Write FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state   <= W_IDLE;
            pend_line <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (wr_hs) begin
                        w_state   <= W_BUSY;
                        pend_line <= w_line;
                    end
                end
                W_BUSY: begin
                    if (mem_wr_done) begin
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule
